// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the fetch-control signals around the PC sequencer.
//   master : hazard/branch side (drives stall, ex_*, resume; observes fetch outputs)
//   slave  : the sequencer (consumes the inputs, drives pc, if_valid, flushes,
//            halted, misalign and the two performance counters)
interface pc_sequencer_if #(
   parameter int PC_W  = 9,
   parameter int CNT_W = 16
);
   logic              stall;
   logic              ex_valid;
   logic              ex_pc_sel;
   logic              ex_halt;
   logic [31:0]       ex_br_pc;
   logic              resume;
   logic [PC_W-1:0]   pc;
   logic              if_valid;
   logic              flush_ifid;
   logic              flush_idex;
   logic              halted;
   logic              misalign;
   logic [CNT_W-1:0]  redirect_cnt;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output stall, ex_valid, ex_pc_sel, ex_halt, ex_br_pc, resume,
      input  pc, if_valid, flush_ifid, flush_idex, halted, misalign,
             redirect_cnt, stall_cnt
   );

   modport slave (
      input  stall, ex_valid, ex_pc_sel, ex_halt, ex_br_pc, resume,
      output pc, if_valid, flush_ifid, flush_idex, halted, misalign,
             redirect_cnt, stall_cnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the fetch program counter. Each cycle it picks one of halt, redirect,
//   stall-hold or sequential advance (in that priority) from the EX-stage
//   branch resolution, drives the pipeline flush strobes, qualifies the
//   synchronous IMEM read with if_valid, and keeps saturating redirect/stall
//   counters.
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   sq       : pc_sequencer_if.slave (inputs stall/ex_*/resume,
//              outputs pc/if_valid/flush_*/halted/misalign/counters)
module pc_sequencer #(
   parameter int PC_W  = 9,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   pc_sequencer_if.slave   sq
);

   typedef enum logic [1:0] {RUN, REDIRECT, HALTED} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              ifv_q, ifv_d;
   logic              halted_q, halted_d;
   logic              mis_q, mis_d;
   logic [CNT_W-1:0]  rcnt_q, rcnt_d;
   logic [CNT_W-1:0]  scnt_q, scnt_d;
   logic              flush;

   logic              halt_ev, redir_ev;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   redir_tgt;

   assign halt_ev   = sq.ex_valid & sq.ex_halt;
   assign redir_ev  = sq.ex_valid & sq.ex_pc_sel & ~sq.ex_halt;
   assign pc_inc    = pc_q + PC_W'(4);   // wraps modulo 2^PC_W
   assign redir_tgt = {sq.ex_br_pc[PC_W-1:2], 2'b00};

   // Target bits above the PC width are dropped on purpose.
   logic unused_br_hi;
   assign unused_br_hi = &{1'b0, sq.ex_br_pc[31:PC_W]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RUN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ifv_d    = ifv_q;
      halted_d = halted_q;
      mis_d    = mis_q;
      rcnt_d   = rcnt_q;
      scnt_d   = scnt_q;
      flush    = 1'b0;
      case (state_q)
         HALTED: begin
            // Everything but resume is ignored; the first fetch after resume
            // is still a bubble because the IMEM read lands one edge later.
            ifv_d = 1'b0;
            if (sq.resume) begin
               pc_d     = pc_inc;
               halted_d = 1'b0;
               state_d  = RUN;
            end
         end
         default: begin   // RUN and REDIRECT decode identically
            if (halt_ev) begin
               flush    = 1'b1;
               pc_d     = sq.ex_br_pc[PC_W-1:0];
               state_d  = HALTED;
               halted_d = 1'b1;
               ifv_d    = 1'b0;
            end else if (redir_ev) begin
               flush   = 1'b1;
               pc_d    = redir_tgt;
               state_d = REDIRECT;
               ifv_d   = 1'b0;
               rcnt_d  = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CNT_W'(1);
               if (sq.ex_br_pc[1:0] != 2'b00) mis_d = 1'b1;
            end else if (sq.stall) begin
               // Hold pc and if_valid; a stalled REDIRECT stays in REDIRECT.
               scnt_d = (scnt_q == CNT_MAX) ? scnt_q : scnt_q + CNT_W'(1);
            end else begin
               pc_d    = pc_inc;
               ifv_d   = 1'b1;
               state_d = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q     <= '0;
         ifv_q    <= 1'b0;
         halted_q <= 1'b0;
         mis_q    <= 1'b0;
         rcnt_q   <= '0;
         scnt_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         ifv_q    <= ifv_d;
         halted_q <= halted_d;
         mis_q    <= mis_d;
         rcnt_q   <= rcnt_d;
         scnt_q   <= scnt_d;
      end
   end

   // Flushes are combinational; gate with reset so none escapes while the
   // state register is being cleared.
   assign sq.flush_ifid   = flush & reset_n;
   assign sq.flush_idex   = flush & reset_n;
   assign sq.pc           = pc_q;
   assign sq.if_valid     = ifv_q;
   assign sq.halted       = halted_q;
   assign sq.misalign     = mis_q;
   assign sq.redirect_cnt = rcnt_q;
   assign sq.stall_cnt    = scnt_q;

endmodule
